scpad_fill_arbiter: RTL and testbench
=====================================

SCPAD_FILL_ARBITER -- requirements
Module: scpad_fill_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of DRAM-response requesters sharing one SRAM write latch.
REQ-002 SHALL have parameter XBAR_W, default 32, width of the packed xbar descriptor (slot_mask, shift_mask, valid_mask).
REQ-003 SHALL have port CLK  in  1  clock; one clock domain, all state on rising edge.
REQ-004 SHALL have port nRST  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester burst request.
REQ-006 SHALL have port req_id  in  NREQx8  per-requester DRAM id.
REQ-007 SHALL have port req_xbar  in  NREQxXBAR_W  per-requester xbar descriptor.
REQ-008 SHALL have port req_num  in  NREQx3  per-requester burst length minus one (1..8 beats).
REQ-009 SHALL have port req_grant  out  NREQ  one-cycle one-hot accept pulse.
REQ-010 SHALL have port beat_valid  in  NREQ  per-requester 64-bit beat valid.
REQ-011 SHALL have port beat_data  in  NREQx64  per-requester beat data.
REQ-012 SHALL have port beat_ready  out  NREQ  per-requester beat accept.
REQ-013 SHALL have port sram_stall  in  1  backend stall.
REQ-014 SHALL have port sram_write_req_latched  in  1  latch has emitted the assembled SRAM write.
REQ-015 SHALL have ports dram_id (8), xbar (XBAR_W), num_request (3), dram_res_valid (1), dram_rddata (64), be_stall (1), all out, driving the write latch.
REQ-016 SHALL have port busy  out  1  burst in progress; err  out  1  sticky protocol error.

Function
REQ-017 SHALL implement FSM states IDLE, BURST, WAIT_LATCH.
REQ-018 IDLE: if any req_valid, SHALL pick a winner by round-robin starting at rr_ptr, pulse req_grant[winner] that cycle, register id/xbar/num and the winner index, clear beat_cnt, go BURST next cycle.
REQ-019 IDLE with no req_valid SHALL remain in IDLE with req_grant=0.
REQ-020 dram_id, xbar, num_request SHALL hold the registered descriptor, stable from the cycle after grant until return to IDLE.
REQ-021 BURST: beat_ready[g]=!sram_stall for the granted g only; all other beat_ready=0; in IDLE and WAIT_LATCH all beat_ready=0.
REQ-022 dram_res_valid SHALL equal beat_valid[g] & beat_ready[g] (combinational); dram_rddata=beat_data[g], else 0.
REQ-023 Each accepted beat SHALL increment the 3-bit beat_cnt; the beat accepted with beat_cnt==num_request SHALL be the last, moving to WAIT_LATCH next cycle.
REQ-024 be_stall SHALL equal sram_stall combinationally in all states.
REQ-025 WAIT_LATCH: on sram_write_req_latched go IDLE, set rr_ptr=(g+1) mod NREQ; else stay.
REQ-026 sram_write_req_latched seen in IDLE or BURST SHALL set err (sticky until reset) and be otherwise ignored.
REQ-027 Latched in the same cycle as the last beat (BURST) SHALL count as error per REQ-026; the FSM still enters WAIT_LATCH.
REQ-028 A granted requester dropping req_valid mid-burst SHALL NOT abort the burst.
REQ-029 busy SHALL be 1 in BURST and WAIT_LATCH, 0 in IDLE.
REQ-030 Grant and latch completion SHALL NOT overlap: a new grant issues no earlier than the cycle after returning to IDLE.

Reset
REQ-031 On nRST low, asynchronously: state=IDLE, rr_ptr=0, beat_cnt=0, registered descriptor=0, err=0; req_grant, beat_ready, dram_res_valid, dram_rddata, dram_id, xbar, num_request, busy all 0.
REQ-032 Reset mid-burst SHALL discard the burst; no beat is forwarded until a new grant after reset release.

Verification
REQ-033 Single burst: req0 valid, id=0x12, num=3, 4 beats back-to-back -> grant0 pulse, 4 dram_res_valid cycles with dram_id=0x12, then WAIT_LATCH; latched -> IDLE, rr_ptr=1.
REQ-034 Contention: req0 and req1 valid from reset -> req0 granted first, req1 granted second, after req0's latched pulse.
REQ-035 Stall: sram_stall high 3 cycles mid-burst (num=7) -> beat_ready=0 and dram_res_valid=0 those cycles, be_stall=1, still exactly 8 beats forwarded.
REQ-036 Non-granted beats: req1 beat_valid during req0 burst -> beat_ready[1]=0, no forwarding of req1 data.
REQ-037 Protocol error: latched pulse in IDLE -> err=1, held until nRST.
REQ-038 Reset mid-burst after 2 of 8 beats -> all outputs 0 immediately; next burst num=0 completes with 1 beat.

Source files
------------

// File: rtl/scpad_fill_arbiter.sv
// Scratchpad fill arbiter: grants one DRAM-response requester at a time
// and steers its burst beats into the shared SRAM write latch.
module scpad_fill_arbiter #(
    parameter int NREQ   = 2,
    parameter int XBAR_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*8-1:0]        req_id,
    input  logic [NREQ*XBAR_W-1:0]   req_xbar,
    input  logic [NREQ*3-1:0]        req_num,
    output logic [NREQ-1:0]          req_grant,
    input  logic [NREQ-1:0]          beat_valid,
    input  logic [NREQ*64-1:0]       beat_data,
    output logic [NREQ-1:0]          beat_ready,
    input  logic                     sram_stall,
    input  logic                     sram_write_req_latched,
    output logic [7:0]               dram_id,
    output logic [XBAR_W-1:0]        xbar,
    output logic [2:0]               num_request,
    output logic                     dram_res_valid,
    output logic [63:0]              dram_rddata,
    output logic                     be_stall,
    output logic                     busy,
    output logic                     err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BURST      = 2'd1,
        WAIT_LATCH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [2:0]          beat_cnt_q, beat_cnt_d;
    logic [7:0]          id_q, id_d;
    logic [XBAR_W-1:0]   xbar_q, xbar_d;
    logic [2:0]          num_q, num_d;
    logic                err_q, err_d;

    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [7:0]          win_id;
    logic [XBAR_W-1:0]   win_xbar;
    logic [2:0]          win_num;
    logic                sel_valid;
    logic [63:0]         sel_data;
    logic                accept;

    // Round-robin pick: the first valid requester at or after rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_id    = '0;
        win_xbar  = '0;
        win_num   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
                win_id    = req_id[idx*8 +: 8];
                win_xbar  = req_xbar[idx*XBAR_W +: XBAR_W];
                win_num   = req_num[idx*3 +: 3];
            end
        end
    end

    // Granted-lane mux for beats, plus per-lane ready and grant pulses.
    always_comb begin
        sel_valid  = 1'b0;
        sel_data   = '0;
        beat_ready = '0;
        req_grant  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == IW'(i)) begin
                sel_valid     = beat_valid[i];
                sel_data      = beat_data[i*64 +: 64];
                beat_ready[i] = (state_q == BURST) && !sram_stall;
            end
            if ((state_q == IDLE) && win_found && (win_idx == IW'(i))) begin
                req_grant[i] = 1'b1;
            end
        end
    end

    assign accept         = sel_valid && (state_q == BURST) && !sram_stall;
    assign dram_res_valid = accept;
    assign dram_rddata    = accept ? sel_data : 64'd0;
    assign be_stall       = sram_stall;
    assign busy           = (state_q != IDLE);
    assign err            = err_q;
    assign dram_id        = id_q;
    assign xbar           = xbar_q;
    assign num_request    = num_q;

    // Next-state logic: grant, count beats, wait for latch completion.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        id_d       = id_q;
        xbar_d     = xbar_q;
        num_d      = num_q;
        err_d      = err_q;
        if (sram_write_req_latched && (state_q != WAIT_LATCH)) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d      = win_idx;
                    id_d       = win_id;
                    xbar_d     = win_xbar;
                    num_d      = win_num;
                    beat_cnt_d = 3'd0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (beat_cnt_q == num_q) begin
                        state_d = WAIT_LATCH;
                    end
                end
            end
            WAIT_LATCH: begin
                if (sram_write_req_latched) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and descriptor registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            id_q       <= '0;
            xbar_q     <= '0;
            num_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            id_q       <= id_d;
            xbar_q     <= xbar_d;
            num_q      <= num_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_scpad_fill_arbiter.sv
// Bench for scpad_fill_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_scpad_fill_arbiter;

    localparam int NREQ   = 2;
    localparam int XBAR_W = 32;

    logic                   CLK;
    logic                   nRST;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*8-1:0]      req_id;
    logic [NREQ*XBAR_W-1:0] req_xbar;
    logic [NREQ*3-1:0]      req_num;
    logic [NREQ-1:0]        req_grant;
    logic [NREQ-1:0]        beat_valid;
    logic [NREQ*64-1:0]     beat_data;
    logic [NREQ-1:0]        beat_ready;
    logic                   sram_stall;
    logic                   sram_write_req_latched;
    logic [7:0]             dram_id;
    logic [XBAR_W-1:0]      xbar;
    logic [2:0]             num_request;
    logic                   dram_res_valid;
    logic [63:0]            dram_rddata;
    logic                   be_stall;
    logic                   busy;
    logic                   err;

    scpad_fill_arbiter #(.NREQ(NREQ), .XBAR_W(XBAR_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_id(req_id), .req_xbar(req_xbar),
        .req_num(req_num), .req_grant(req_grant),
        .beat_valid(beat_valid), .beat_data(beat_data),
        .beat_ready(beat_ready), .sram_stall(sram_stall),
        .sram_write_req_latched(sram_write_req_latched),
        .dram_id(dram_id), .xbar(xbar), .num_request(num_request),
        .dram_res_valid(dram_res_valid), .dram_rddata(dram_rddata),
        .be_stall(be_stall), .busy(busy), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int fwd_cnt = 0;

    // Reference model: who owns the latch, beats still owed, rr pointer.
    int          m_owner;
    int          m_left;
    int          m_rr;
    bit          m_err;
    logic [7:0]  m_id;
    logic [31:0] m_xbar;
    logic [2:0]  m_num;

    typedef struct packed {
        logic [1:0] rv;
        logic [1:0] bv;
        logic       stall;
        logic       lat;
        logic [1:0] eg;
        logic [1:0] er;
        logic       ev;
        logic       ebusy;
        logic [7:0] eid;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] bv,
                                input logic st, input logic lat,
                                input logic [1:0] eg, input logic [1:0] er,
                                input logic ev, input logic eb,
                                input logic [7:0] eid);
        vec_t v;
        v.rv = rv; v.bv = bv; v.stall = st; v.lat = lat;
        v.eg = eg; v.er = er; v.ev = ev; v.ebusy = eb; v.eid = eid;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_rr    = 0;
        m_err   = 0;
        m_id    = '0;
        m_xbar  = '0;
        m_num   = '0;
    endtask

    task automatic zero_inputs();
        req_valid = '0;
        req_id = '0;
        req_xbar = '0;
        req_num = '0;
        beat_valid = '0;
        beat_data = '0;
        sram_stall = 1'b0;
        sram_write_req_latched = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        zero_inputs();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_grant", 64'(req_grant), 64'd0);
        chk("rst_ready", 64'(beat_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_id", 64'(dram_id), 64'd0);
        nRST = 1'b1;
        model_reset();
    endtask

    // One clock of model-checked operation; inputs are already applied.
    task automatic mcycle();
        logic [1:0]  eg;
        logic [1:0]  er;
        logic        ev;
        logic [63:0] ed;
        int          w;
        @(negedge CLK);
        eg = '0; er = '0; ev = 1'b0; ed = '0; w = -1;
        if (m_owner < 0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        if (m_owner >= 0 && m_left > 0 && !sram_stall) er[m_owner] = 1'b1;
        if (m_owner >= 0) ev = er[m_owner] & beat_valid[m_owner];
        if (ev) ed = beat_data[m_owner*64 +: 64];
        chk("m_grant", 64'(req_grant), 64'(eg));
        chk("m_ready", 64'(beat_ready), 64'(er));
        chk("m_rvalid", 64'(dram_res_valid), 64'(ev));
        chk("m_rdata", dram_rddata, ed);
        chk("m_busy", 64'(busy), 64'(m_owner >= 0));
        chk("m_bestall", 64'(be_stall), 64'(sram_stall));
        chk("m_err", 64'(err), 64'(m_err));
        if (m_owner >= 0) begin
            chk("m_id", 64'(dram_id), 64'(m_id));
            chk("m_xbar", 64'(xbar), 64'(m_xbar));
            chk("m_num", 64'(num_request), 64'(m_num));
        end
        if (dram_res_valid === 1'b1) fwd_cnt++;
        if (sram_write_req_latched && !(m_owner >= 0 && m_left == 0)) m_err = 1;
        if (w >= 0) begin
            m_owner = w;
            m_left  = int'(req_num[w*3 +: 3]) + 1;
            m_id    = req_id[w*8 +: 8];
            m_xbar  = req_xbar[w*XBAR_W +: XBAR_W];
            m_num   = req_num[w*3 +: 3];
        end else if (ev) begin
            m_left--;
        end else if (m_owner >= 0 && m_left == 0 && sram_write_req_latched) begin
            m_rr    = (m_owner + 1) % NREQ;
            m_owner = -1;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        zero_inputs();
        model_reset();

        // Directed vector table: burst, contention, stall, round-robin.
        tbl[0]  = mk(2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 8'h00);
        tbl[1]  = mk(2'b10, 2'b01, 0, 0, 2'b00, 2'b01, 1, 1, 8'h12);
        tbl[2]  = mk(2'b10, 2'b01, 0, 0, 2'b00, 2'b01, 1, 1, 8'h12);
        tbl[3]  = mk(2'b10, 2'b01, 1, 0, 2'b00, 2'b00, 0, 1, 8'h12);
        tbl[4]  = mk(2'b10, 2'b01, 0, 0, 2'b00, 2'b01, 1, 1, 8'h12);
        tbl[5]  = mk(2'b10, 2'b01, 0, 0, 2'b00, 2'b01, 1, 1, 8'h12);
        tbl[6]  = mk(2'b10, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1, 8'h12);
        tbl[7]  = mk(2'b10, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1, 8'h12);
        tbl[8]  = mk(2'b11, 2'b00, 0, 0, 2'b10, 2'b00, 0, 0, 8'h00);
        tbl[9]  = mk(2'b00, 2'b10, 0, 0, 2'b00, 2'b10, 1, 1, 8'h34);
        tbl[10] = mk(2'b00, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1, 8'h34);
        tbl[11] = mk(2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1, 8'h34);
        tbl[12] = mk(2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 8'h00);

        do_reset();
        req_id   = {8'h34, 8'h12};
        req_num  = {3'd0, 3'd3};
        req_xbar = {32'hCAFE_0001, 32'hBEEF_0000};
        for (int r = 0; r < 13; r++) begin
            logic [63:0] ed;
            req_valid  = tbl[r].rv;
            beat_valid = tbl[r].bv;
            sram_stall = tbl[r].stall;
            sram_write_req_latched = tbl[r].lat;
            beat_data  = {64'h1111_0000_0000_0000 + 64'(r),
                          64'hAAAA_0000_0000_0000 + 64'(r)};
            ed = '0;
            if (tbl[r].ev) ed = tbl[r].er[1] ? beat_data[127:64] : beat_data[63:0];
            @(negedge CLK);
            chk($sformatf("t%0d_grant", r), 64'(req_grant), 64'(tbl[r].eg));
            chk($sformatf("t%0d_ready", r), 64'(beat_ready), 64'(tbl[r].er));
            chk($sformatf("t%0d_rvalid", r), 64'(dram_res_valid), 64'(tbl[r].ev));
            chk($sformatf("t%0d_rdata", r), dram_rddata, ed);
            chk($sformatf("t%0d_busy", r), 64'(busy), 64'(tbl[r].ebusy));
            chk($sformatf("t%0d_bestall", r), 64'(be_stall), 64'(tbl[r].stall));
            chk($sformatf("t%0d_err", r), 64'(err), 64'd0);
            if (tbl[r].ebusy) chk($sformatf("t%0d_id", r), 64'(dram_id), 64'(tbl[r].eid));
            @(posedge CLK);
            #1;
        end

        // Stall mid-burst of 8 beats, with req1 beats that must be ignored.
        do_reset();
        req_valid = 2'b01;
        req_id    = {8'h77, 8'h55};
        req_num   = {3'd2, 3'd7};
        mcycle();
        req_valid  = 2'b00;
        beat_valid = 2'b11;
        fwd_cnt    = 0;
        for (int i = 0; i < 16; i++) begin
            sram_stall = (i >= 2 && i < 5);
            beat_data  = {64'hBAD0_0000_0000_0000 + 64'(i),
                          64'h600D_0000_0000_0000 + 64'(i)};
            #1;
            chk("s_ready1", 64'(beat_ready[1]), 64'd0);
            if (sram_stall) begin
                chk("s_stall_ready", 64'(beat_ready), 64'd0);
                chk("s_stall_rvalid", 64'(dram_res_valid), 64'd0);
                chk("s_stall_bestall", 64'(be_stall), 64'd1);
            end
            if (dram_res_valid === 1'b1) chk("s_no_req1", dram_rddata, beat_data[63:0]);
            mcycle();
        end
        beat_valid = 2'b00;
        sram_stall = 1'b0;
        chk("s_beats", 64'(fwd_cnt), 64'd8);
        chk("s_waiting", 64'(busy), 64'd1);
        sram_write_req_latched = 1'b1;
        mcycle();
        sram_write_req_latched = 1'b0;
        mcycle();

        // Latch pulse while idle is a sticky error.
        do_reset();
        sram_write_req_latched = 1'b1;
        mcycle();
        sram_write_req_latched = 1'b0;
        repeat (3) mcycle();
        chk("e_sticky", 64'(err), 64'd1);

        // Reset after 2 of 8 beats, then a single-beat burst.
        do_reset();
        req_valid = 2'b01;
        req_id    = {8'h00, 8'h9A};
        req_xbar  = {32'h0, 32'h1234_5678};
        req_num   = {3'd0, 3'd7};
        mcycle();
        req_valid  = 2'b00;
        beat_valid = 2'b01;
        beat_data  = {64'h0, 64'h0123_4567_89AB_CDEF};
        repeat (2) mcycle();
        #2;
        nRST = 1'b0;
        #1;
        chk("r_grant", 64'(req_grant), 64'd0);
        chk("r_ready", 64'(beat_ready), 64'd0);
        chk("r_rvalid", 64'(dram_res_valid), 64'd0);
        chk("r_rdata", dram_rddata, 64'd0);
        chk("r_id", 64'(dram_id), 64'd0);
        chk("r_xbar", 64'(xbar), 64'd0);
        chk("r_num", 64'(num_request), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
        fwd_cnt = 0;
        mcycle();
        req_valid = 2'b01;
        req_num   = {3'd0, 3'd0};
        mcycle();
        req_valid = 2'b00;
        repeat (3) mcycle();
        chk("r_one_beat", 64'(fwd_cnt), 64'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 299) do_reset();
            req_valid  = 2'($urandom);
            req_id     = 16'($urandom);
            req_xbar   = {32'($urandom), 32'($urandom)};
            req_num    = 6'($urandom);
            beat_valid = 2'($urandom);
            beat_data  = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            sram_stall = ($urandom_range(0, 3) == 0);
            if (m_owner >= 0 && m_left == 0)
                sram_write_req_latched = ($urandom_range(0, 2) == 0);
            else
                sram_write_req_latched = ($urandom_range(0, 49) == 0);
            mcycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
